fact_accel: RTL and testbench
=============================

// Module: fact_accel
// PURPOSE
//  Memory-mapped iterative factorial accelerator on the data bus at 0x0000_080x.
//  Downstream of the address decoder: consumes its write-enable (we1) and the low address bits.
//  Returns read data to the read-select mux on input 2.
//  Software writes N, pulses GO, polls STATUS, then reads RESULT.
// PARAMETERS
//  DW     32  data/result width
//  NW      4  width of operand N
//  MAX_N  12  largest N whose N! fits in DW bits; N > MAX_N is an error
// PORTS
//  clk    in   1   system clock, all state on rising edge
//  rst_n  in   1   asynchronous, active-low reset
//  we     in   1   write strobe for this block (decoder we1)
//  a      in   2   register select = bus address [3:2]
//  wd     in   DW  bus write data
//  rd     out  DW  read data, combinational from a
//  irq    out  1   done interrupt (only with FACT_IRQ_EN, else absent)
// BEHAVIOUR
//  Register map (a):
//   0 N       RW  [NW-1:0]; other bits read 0
//   1 GO      WO  write with wd[0]=1 starts; reads 0
//   2 STATUS  RO  {29'b0, busy, err, done}
//   3 RESULT  RO  product register
//  Reset: N=0, result=0, done=0, err=0, busy=0, state=IDLE, irq=0.
//  FSM IDLE -> LOAD -> MULT -> DONE:
//   IDLE: GO write with wd[0]=1 -> LOAD; done<=0, err<=0, busy<=1.
//   LOAD: if N>MAX_N -> DONE with err=1, result=0; else prod<=1, cnt<=N -> MULT.
//   MULT: cnt<=1 -> DONE; else prod<=prod*cnt (low DW bits), cnt<=cnt-1.
//   DONE: busy<=0, done<=1, result<=prod (or 0 on err) -> IDLE in the same edge.
//  Latency: GO edge E0; done visible after edge E0+max(N,1)+2; err visible after E0+2.
//  done/err/RESULT hold until the next accepted GO.
//  While busy: writes to N and GO are ignored; reads remain valid.
//  GO with wd[0]=0 is ignored.
//  N=0 and N=1 both give RESULT=1.
//  Simultaneous N write and GO are impossible: single-port bus, one a per cycle.
//  rst_n low mid-computation aborts at once: all state returns to reset values.
//  we with unmapped a is not possible; 2-bit a fully decoded.
// CONFIGURATION
//  FACT_IRQ_EN defined:
//   irq port exists; irq set on entry to DONE.
//   irq cleared by any write to STATUS address (a=2) or by an accepted GO.
//  FACT_IRQ_EN undefined:
//   no irq port, no irq flop; software polls STATUS only.
// STRUCTURE
//  Package fact_pkg:
//   register offsets REG_N=0, REG_GO=1, REG_STATUS=2, REG_RESULT=3
//   state typedef/encodings S_IDLE, S_LOAD, S_MULT, S_DONE
//   STATUS bit indices DONE_B=0, ERR_B=1, BUSY_B=2
//  Sub-module fact_dp:
//   cnt and prod registers and the DW x NW multiplier
//   controlled by load/step strobes from the fact_accel FSM; exports cnt_le1
// TESTING
//  1 Reset: rst_n low -> rd = 0 at all four addresses, irq=0.
//  2 N=5, GO -> STATUS=0x4 while busy; STATUS=0x1 at E0+7; RESULT=0x78.
//  3 N=12 -> RESULT=0x1C8CFC00; N=0 and N=1 -> RESULT=1, done after E0+3.
//  4 N=13 -> STATUS=0x3 at E0+2, RESULT=0.
//  5 Busy protection: N=6, GO, then write N=3 and GO mid-run.
//    -> N reads 6; RESULT=0x2D0; single done.
//  6 Reset abort: assert rst_n during MULT -> all regs 0, busy=0.
//    With FACT_IRQ_EN: irq rises with done; STATUS write clears it.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared constants, register offsets and FSM encoding for the factorial accelerator.
package fact_pkg;

   localparam int unsigned DW    = 32;
   localparam int unsigned NW    = 4;
   localparam int unsigned MAX_N = 12;
   localparam int unsigned AW    = 2;

   localparam logic [AW-1:0] REG_N      = 2'd0;
   localparam logic [AW-1:0] REG_GO     = 2'd1;
   localparam logic [AW-1:0] REG_STATUS = 2'd2;
   localparam logic [AW-1:0] REG_RESULT = 2'd3;

   localparam int unsigned DONE_B = 0;
   localparam int unsigned ERR_B  = 1;
   localparam int unsigned BUSY_B = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_MULT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Packs the status flags into a bus-wide word.
   function automatic logic [DW-1:0] status_word(input logic busy, input logic err,
                                                 input logic done);
      logic [DW-1:0] w;
      w         = '0;
      w[BUSY_B] = busy;
      w[ERR_B]  = err;
      w[DONE_B] = done;
      return w;
   endfunction

endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: down-counter and running product with a DW x NW multiplier.
module fact_dp
   import fact_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          step,
   input  logic [NW-1:0] n,
   output logic [DW-1:0] prod,
   output logic          cnt_le1
);

   logic [NW-1:0] cnt;
   logic [DW-1:0] prod_next;

   // Only the low DW bits of the product are kept.
   assign prod_next = prod * DW'(cnt);
   assign cnt_le1   = (cnt <= NW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod <= '0;
         cnt  <= '0;
      end else if (load) begin
         prod <= DW'(1);
         cnt  <= n;
      end else if (step) begin
         prod <= prod_next;
         cnt  <= cnt - NW'(1);
      end
   end

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator (N, GO, STATUS, RESULT registers).
// Optional done interrupt output enabled by defining FACT_IRQ_EN.
module fact_accel
   import fact_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] a,
   input  logic [DW-1:0] wd,
   output logic [DW-1:0] rd
`ifdef FACT_IRQ_EN
   ,
   output logic          irq
`endif
);

   state_t        state;
   state_t        state_nxt;
   logic [NW-1:0] n;
   logic [DW-1:0] result;
   logic          busy;
   logic          err;
   logic          done;

   logic          idle;
   logic          go_acc;
   logic          n_wr;
   logic          n_err;
   logic          dp_load;
   logic          dp_step;
   logic          finish;
   logic [DW-1:0] prod;
   logic          cnt_le1;
   logic          wd_unused;

   assign idle      = (state == S_IDLE);
   assign go_acc    = we && (a == REG_GO) && wd[0] && idle;
   assign n_wr      = we && (a == REG_N) && idle;
   assign n_err     = (n > NW'(MAX_N));
   assign wd_unused = ^wd[DW-1:NW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (go_acc) state_nxt = S_LOAD;
         S_LOAD: state_nxt = n_err ? S_DONE : S_MULT;
         S_MULT: if (cnt_le1) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      dp_load = 1'b0;
      dp_step = 1'b0;
      finish  = 1'b0;
      case (state)
         S_LOAD: dp_load = !n_err;
         S_MULT: dp_step = !cnt_le1;
         S_DONE: finish  = 1'b1;
         default: ;
      endcase
   end

   fact_dp u_dp (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (dp_load),
      .step    (dp_step),
      .n       (n),
      .prod    (prod),
      .cnt_le1 (cnt_le1)
   );

   // N is stable while busy, so the error decision can be re-evaluated at completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n      <= '0;
         result <= '0;
         busy   <= 1'b0;
         err    <= 1'b0;
         done   <= 1'b0;
      end else begin
         if (n_wr) n <= wd[NW-1:0];
         if (go_acc) begin
            busy <= 1'b1;
            done <= 1'b0;
            err  <= 1'b0;
         end
         if (finish) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            err    <= n_err;
            result <= n_err ? '0 : prod;
         end
      end
   end

`ifdef FACT_IRQ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  irq <= 1'b0;
      else if (finish)                             irq <= 1'b1;
      else if ((we && (a == REG_STATUS)) || go_acc) irq <= 1'b0;
   end
`endif

   always_comb begin
      rd = '0;
      case (a)
         REG_N:      rd = DW'(n);
         REG_GO:     rd = '0;
         REG_STATUS: rd = status_word(busy, err, done);
         REG_RESULT: rd = result;
         default:    rd = '0;
      endcase
   end

endmodule

// File: tb/tb_fact_accel.sv
// Self-checking bench for fact_accel against a plain-arithmetic factorial model.
module tb_fact_accel;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  a = 2'd0;
   logic [31:0] wd = 32'd0;
   logic [31:0] rd;
`ifdef FACT_IRQ_EN
   logic        irq;
`endif

   int passed = 0;
   int total  = 0;

   fact_accel dut (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .a     (a),
      .wd    (wd),
      .rd    (rd)
`ifdef FACT_IRQ_EN
      ,
      .irq   (irq)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_fact(input int n);
      logic [31:0] p;
      if (n > 12) return 32'd0;
      p = 32'd1;
      for (int i = 2; i <= n; i++) p = p * 32'(i);
      return p;
   endfunction

   function automatic int ref_lat(input int n);
      if (n > 12) return 2;
      return ((n < 1) ? 1 : n) + 2;
   endfunction

   task automatic wr(input logic [1:0] ad, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1;
      a  = ad;
      wd = d;
      @(posedge clk);
      #1;
      we = 1'b0;
      wd = 32'd0;
   endtask

   // Full transaction: program N, GO, track STATUS every cycle, read RESULT.
   task automatic run_one(input int n);
      int          lat;
      logic [31:0] exp_st;
      lat = ref_lat(n);
      wr(2'd0, 32'(n));
      a = 2'd0; #1;
      total++;
      if (rd !== 32'(n)) $display("FAIL n_read n=%0d got %h exp %h", n, rd, 32'(n));
      else passed++;
      wr(2'd1, 32'd1);
      a = 2'd2;
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         exp_st = (k < lat) ? 32'h4 : ((n > 12) ? 32'h3 : 32'h1);
         total++;
         if (rd !== exp_st) $display("FAIL status n=%0d k=%0d got %h exp %h", n, k, rd, exp_st);
         else passed++;
`ifdef FACT_IRQ_EN
         total++;
         if (irq !== (k == lat)) $display("FAIL irq n=%0d k=%0d got %b exp %b", n, k, irq, (k == lat));
         else passed++;
`endif
      end
      a = 2'd3; #1;
      total++;
      if (rd !== ref_fact(n)) $display("FAIL result n=%0d got %h exp %h", n, rd, ref_fact(n));
      else passed++;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         a = 2'(i); #1;
         total++;
         if (rd !== 32'd0) $display("FAIL reset_rd a=%0d got %h exp 0", i, rd);
         else passed++;
      end
`ifdef FACT_IRQ_EN
      total++;
      if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq);
      else passed++;
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      run_one(5);
   endtask

   task automatic test_boundaries();
      run_one(12);
      run_one(0);
      run_one(1);
      run_one(13);
      run_one(15);
      run_one(2);
   endtask

   task automatic test_go_zero();
      wr(2'd1, 32'd2);
      a = 2'd2;
      repeat (3) begin
         @(posedge clk); #1;
         total++;
         if (rd !== 32'h1) $display("FAIL go_zero_status got %h exp 00000001", rd);
         else passed++;
      end
   endtask

   task automatic test_busy();
      int first_done = -1;
      int rebusy     = 0;
      int cyc        = 2;
      wr(2'd0, 32'd6);
      wr(2'd1, 32'd1);
      wr(2'd0, 32'd3);
      wr(2'd1, 32'd1);
      a = 2'd2;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (first_done < 0 && rd === 32'h1) first_done = cyc;
         else if (first_done >= 0 && rd !== 32'h1) rebusy++;
      end
      total++;
      if (first_done !== 8) $display("FAIL busy_done_edge got %0d exp 8", first_done);
      else passed++;
      total++;
      if (rebusy !== 0) $display("FAIL busy_single_done got %0d extra exp 0", rebusy);
      else passed++;
      a = 2'd0; #1;
      total++;
      if (rd !== 32'd6) $display("FAIL busy_n_kept got %h exp 00000006", rd);
      else passed++;
      a = 2'd3; #1;
      total++;
      if (rd !== ref_fact(6)) $display("FAIL busy_result got %h exp %h", rd, ref_fact(6));
      else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) run_one(int'($urandom_range(0, 15)));
   endtask

`ifdef FACT_IRQ_EN
   task automatic test_irq();
      run_one(4);
      wr(2'd2, 32'hFFFF_FFFF);
      total++;
      if (irq !== 1'b0) $display("FAIL irq_clear got %b exp 0", irq);
      else passed++;
      a = 2'd2; #1;
      total++;
      if (rd !== 32'h1) $display("FAIL irq_status_ro got %h exp 00000001", rd);
      else passed++;
   endtask
`endif

   task automatic test_reset_abort();
      wr(2'd0, 32'd7);
      wr(2'd1, 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = 2'(i); #1;
         total++;
         if (rd !== 32'd0) $display("FAIL abort_rd a=%0d got %h exp 0", i, rd);
         else passed++;
      end
`ifdef FACT_IRQ_EN
      total++;
      if (irq !== 1'b0) $display("FAIL abort_irq got %b exp 0", irq);
      else passed++;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1; a = 2'd2; #1;
      total++;
      if (rd !== 32'd0) $display("FAIL abort_idle_status got %h exp 0", rd);
      else passed++;
      run_one(3);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_go_zero();
      test_busy();
      test_random();
`ifdef FACT_IRQ_EN
      test_irq();
`endif
      test_reset_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
